alu_sequencer: RTL
==================

// Module: alu_sequencer
// PURPOSE
//  Multi-cycle command sequencer in front of the 16-bit ALU datapath. Accepts register-to-register
//  ALU commands over a valid/ready handshake, reads operands from an internal register file,
//  drives the external ALU's A/B/F/Cin, then writes back Result and the 6-bit Status flags.
//  Keeps the carry flag architectural, so ADC/SBB/RCL/RCR chain across commands.
// PARAMETERS
//  REG_AW   3   register-index width; register file holds 2**REG_AW 16-bit registers
// PORTS
//  clk          in   1       single clock; all state updates on rising edge
//  rst_n        in   1       synchronous, active-low reset
//  cmd_valid    in   1       command present
//  cmd_ready    out  1       sequencer can accept a command
//  cmd_op       in   5       ALU function code (F encoding)
//  cmd_rd       in   REG_AW  destination register
//  cmd_rs1      in   REG_AW  source for ALU A
//  cmd_rs2      in   REG_AW  source for ALU B (ignored by unary/shift ops, still driven)
//  ld_en        in   1       direct register-file load strobe
//  ld_addr      in   REG_AW  load target register
//  ld_data      in   16      load data
//  alu_a        out  16      to ALU A
//  alu_b        out  16      to ALU B
//  alu_f        out  5       to ALU F
//  alu_cin      out  1       to ALU Cin (= flag register bit 5, carry)
//  alu_result   in   16      from ALU Result
//  alu_status   in   6       from ALU Status {C,Z,N,V,P,AC}
//  rsp_valid    out  1       response present
//  rsp_ready    in   1       response consumer ready
//  rsp_result   out  16      captured ALU result
//  rsp_status   out  6       flag register after the command
//  rsp_err      out  1       1 = illegal opcode, no writeback
//  flags        out  6       architectural flag register
// BEHAVIOUR
//  - Reset (rst_n=0 at edge): state IDLE; all registers, flags, alu_a/b/f, rsp_* = 0; cmd_ready=0
//    during the reset cycle. Reset aborts any command in flight; its writeback/response is dropped.
//  - FSM: IDLE -> EXEC -> RESP -> IDLE.
//    IDLE: cmd_ready = ~ld_en. Accept on cmd_valid & cmd_ready: register alu_a=R[rs1],
//      alu_b=R[rs2], alu_f=cmd_op, latch rd; go EXEC.
//    EXEC (1 cycle): ALU is combinational; at the end of the cycle capture alu_result/alu_status.
//      Legal op: R[rd] <= alu_result, flags <= alu_status, rsp_err <= 0.
//      Illegal op: no register or flag write, rsp_result <= 0, rsp_err <= 1. Go RESP.
//    RESP: rsp_valid=1; rsp_result/rsp_status/rsp_err held stable until rsp_ready; on
//      rsp_valid & rsp_ready go IDLE (cmd_ready=1 next cycle at earliest).
//  - Latency: accept edge at cycle 0 -> rsp_valid high in cycle 2; peak throughput 1 cmd / 3 cycles.
//  - Legal ops: 01,03,04,05,06,07,08,09,0A,0B,10..17 (hex). All others illegal.
//  - alu_cin = flags[5] continuously; the carry used is the one from the previous legal command.
//  - Load port: honoured only in IDLE; R[ld_addr] <= ld_data; flags untouched. ld_en outside IDLE
//    is ignored. ld_en has priority: cmd_ready=0 in that cycle, so no same-cycle collision.
//  - rd may equal rs1/rs2: operands are registered at accept, so read-before-write always holds.
//  - alu_a/b/f hold their last values outside EXEC (no glitch requirement on ALU inputs).
// TESTING
//  1. Load R1=FFFF, R2=0001; ADD(04) rd=3 -> rsp_result=0000, rsp_status C=1,Z=1, R3=0000, rsp_valid in cycle 2.
//  2. After test 1, ADC(05) rd=4 rs1=2 rs2=2 -> alu_cin=1, R4=0003, C=0.
//  3. Illegal op 5'b00010 rd=3 -> rsp_err=1, rsp_result=0, R3 and flags unchanged.
//  4. Hold rsp_ready=0 for 5 cycles -> rsp_valid/rsp_result stable, cmd_ready=0; released -> IDLE.
//  5. ld_en and cmd_valid in same IDLE cycle -> load written, cmd not accepted until next cycle.
//  6. Assert rst_n=0 during EXEC of ADD rd=5 -> R5=0, flags=0, no rsp_valid, state IDLE.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle command sequencer in front of a combinational 16-bit ALU.
// Reads operands from an internal register file, drives the ALU, then writes back the
// result and the architectural flags. The carry flag chains across commands via alu_cin.
`timescale 1ns/1ps

module alu_sequencer #(
    parameter int unsigned REG_AW = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [4:0]        cmd_op,
    input  logic [REG_AW-1:0] cmd_rd,
    input  logic [REG_AW-1:0] cmd_rs1,
    input  logic [REG_AW-1:0] cmd_rs2,
    input  logic              ld_en,
    input  logic [REG_AW-1:0] ld_addr,
    input  logic [15:0]       ld_data,
    output logic [15:0]       alu_a,
    output logic [15:0]       alu_b,
    output logic [4:0]        alu_f,
    output logic              alu_cin,
    input  logic [15:0]       alu_result,
    input  logic [5:0]        alu_status,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [15:0]       rsp_result,
    output logic [5:0]        rsp_status,
    output logic              rsp_err,
    output logic [5:0]        flags
);

    localparam int unsigned NumRegs = 2 ** REG_AW;

    typedef enum logic [1:0] {
        StIdle,
        StExec,
        StResp
    } state_e;

    state_e              state_q, state_d;
    logic [15:0]         regs_q [NumRegs];
    logic [5:0]          flags_q;
    logic [15:0]         alu_a_q, alu_b_q;
    logic [4:0]          alu_f_q;
    logic [REG_AW-1:0]   rd_q;
    logic [15:0]         rsp_result_q;
    logic [5:0]          rsp_status_q;
    logic                rsp_err_q;
    logic                cmd_accept;
    logic                op_legal;
    logic                in_idle;
    logic                in_exec;

    assign in_idle    = (state_q == StIdle);
    assign in_exec    = (state_q == StExec);
    assign cmd_accept = cmd_valid & cmd_ready;

    assign alu_a      = alu_a_q;
    assign alu_b      = alu_b_q;
    assign alu_f      = alu_f_q;
    assign alu_cin    = flags_q[5];
    assign flags      = flags_q;
    assign rsp_result = rsp_result_q;
    assign rsp_status = rsp_status_q;
    assign rsp_err    = rsp_err_q;

    // Opcode legality, decoded from the latched function code during EXEC.
    always_comb begin
        op_legal = 1'b0;
        case (alu_f_q)
            5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09, 5'h0A, 5'h0B,
            5'h10, 5'h11, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    end

    // State register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state and handshake outputs; a load strobe blocks command acceptance that cycle.
    always_comb begin
        state_d   = state_q;
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        case (state_q)
            StIdle: begin
                cmd_ready = rst_n & ~ld_en;
                if (cmd_valid && rst_n && !ld_en) begin
                    state_d = StExec;
                end
            end
            StExec: begin
                state_d = StResp;
            end
            StResp: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Operand capture at accept; ALU inputs hold their values until the next accept.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            alu_a_q <= '0;
            alu_b_q <= '0;
            alu_f_q <= '0;
            rd_q    <= '0;
        end else if (cmd_accept) begin
            alu_a_q <= regs_q[cmd_rs1];
            alu_b_q <= regs_q[cmd_rs2];
            alu_f_q <= cmd_op;
            rd_q    <= cmd_rd;
        end
    end

    // Register file and flags: direct loads in IDLE, ALU writeback at the end of a legal EXEC.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NumRegs; i++) begin
                regs_q[i] <= '0;
            end
            flags_q <= '0;
        end else begin
            if (in_idle && ld_en) begin
                regs_q[ld_addr] <= ld_data;
            end
            if (in_exec && op_legal) begin
                regs_q[rd_q] <= alu_result;
                flags_q      <= alu_status;
            end
        end
    end

    // Response capture; an illegal op reports the unchanged flags with a zero result.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rsp_result_q <= '0;
            rsp_status_q <= '0;
            rsp_err_q    <= 1'b0;
        end else if (in_exec) begin
            rsp_result_q <= op_legal ? alu_result : 16'h0000;
            rsp_status_q <= op_legal ? alu_status : flags_q;
            rsp_err_q    <= ~op_legal;
        end
    end

endmodule
